// File: rtl/r2sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage: shift enable, butterfly select, twiddle address, output framing.
// Optional sticky protocol checker enabled by defining R2SDF_CTRL_PROTO_CHK_EN.
module r2sdf_stage_ctrl #(
  parameter int N     = 16,
  parameter int STAGE = 0,
  localparam int LOG2N = $clog2(N),
  localparam int TW_W  = (LOG2N > 1) ? LOG2N - 1 : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            dl_shift,
  output logic            bf_sel,
  output logic            tw_en,
  output logic [TW_W-1:0] tw_addr,
  output logic            out_valid,
  output logic            out_last,
  output logic            busy,
  output logic            proto_err
);

  localparam int D     = N >> (STAGE + 1);
  localparam int LOG2D = $clog2(D);

  localparam logic [LOG2N-1:0] D_LAST = LOG2N'(D - 1);
  localparam logic [LOG2N-1:0] D_MASK = LOG2N'(D - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // With a one-sample delay line the first accept already completes the fill.
  localparam logic [1:0] S_AFTER_IDLE = (D == 1) ? S_RUN : S_FILL;

  logic [1:0]       state;
  logic [LOG2N-1:0] cnt;
  logic             accept;
  logic             adv;
  logic             sel_int;
  logic             valid_int;
  logic             tw_en_int;

  always_comb begin
    accept    = in_valid & (state != S_FLUSH);
    adv       = accept | (state == S_FLUSH);
    sel_int   = ((state == S_FILL) || (state == S_RUN)) ? cnt[LOG2D] : 1'b0;
    valid_int = ((state == S_RUN) & in_valid) | (state == S_FLUSH);
    tw_en_int = valid_int & ~sel_int;
  end

  // Every output is held low while reset is asserted, including in_ready.
  always_comb begin
    in_ready  = 1'b0;
    dl_shift  = 1'b0;
    bf_sel    = 1'b0;
    tw_en     = 1'b0;
    tw_addr   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      in_ready  = (state != S_FLUSH);
      dl_shift  = adv;
      bf_sel    = sel_int;
      tw_en     = tw_en_int;
      tw_addr   = tw_en_int ? (TW_W'(cnt & D_MASK) << STAGE) : '0;
      out_valid = valid_int;
      out_last  = valid_int & (cnt == D_LAST);
      busy      = (state != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      if (adv) cnt <= cnt + 1'b1;
      case (state)
        S_IDLE:  if (accept) state <= S_AFTER_IDLE;
        S_FILL:  if (accept && (cnt == D_LAST)) state <= S_RUN;
        // A sample arriving together with a flush request at cnt==0 takes priority.
        S_RUN:   if (flush && (cnt == '0) && !accept) state <= S_FLUSH;
        S_FLUSH: begin
          if (cnt == D_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef R2SDF_CTRL_PROTO_CHK_EN
  logic perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (flush && ((state == S_FILL) || ((state == S_RUN) && (cnt != '0)))) begin
      perr <= 1'b1;
    end
  end

  assign proto_err = perr & ~rst;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// [TB] bench for r2sdf_stage_ctrl: three instances (STAGE 0, 1, 3) driven by directed steps with a scoreboard queue.
module tb_r2sdf_stage_ctrl;

`ifdef R2SDF_CTRL_PROTO_CHK_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] iv_v;
  logic [2:0] fl_v;
  logic [2:0] ir, ds, bs, te, ov, ol, by, pe;
  logic [2:0] tw0, tw1, tw3;

  int checks = 0;
  int errors = 0;
  bit perr0  = 1'b0;

  typedef struct {
    string      tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];

  r2sdf_stage_ctrl #(.N(16), .STAGE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(iv_v[0]), .in_ready(ir[0]), .flush(fl_v[0]),
    .dl_shift(ds[0]), .bf_sel(bs[0]), .tw_en(te[0]), .tw_addr(tw0),
    .out_valid(ov[0]), .out_last(ol[0]), .busy(by[0]), .proto_err(pe[0])
  );

  r2sdf_stage_ctrl #(.N(16), .STAGE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(iv_v[1]), .in_ready(ir[1]), .flush(fl_v[1]),
    .dl_shift(ds[1]), .bf_sel(bs[1]), .tw_en(te[1]), .tw_addr(tw1),
    .out_valid(ov[1]), .out_last(ol[1]), .busy(by[1]), .proto_err(pe[1])
  );

  r2sdf_stage_ctrl #(.N(16), .STAGE(3)) u3 (
    .clk(clk), .rst(rst_v[2]), .in_valid(iv_v[2]), .in_ready(ir[2]), .flush(fl_v[2]),
    .dl_shift(ds[2]), .bf_sel(bs[2]), .tw_en(te[2]), .tw_addr(tw3),
    .out_valid(ov[2]), .out_last(ol[2]), .busy(by[2]), .proto_err(pe[2])
  );

  function automatic logic [10:0] mk(bit r, bit d, bit b, bit t, logic [2:0] a,
                                     bit v, bit l, bit y, bit p);
    return {r, d, b, t, a, v, l, y, p};
  endfunction

  function automatic logic [10:0] obsVec(int s);
    logic [2:0] a;
    a = (s == 0) ? tw0 : ((s == 1) ? tw1 : tw3);
    return {ir[s], ds[s], bs[s], te[s], a, ov[s], ol[s], by[s], pe[s]};
  endfunction

  // Pops the oldest expectation and compares it against the selected instance.
  task automatic checkOutput(int s);
    exp_t       x;
    logic [10:0] o;
    x = sb.pop_front();
    o = obsVec(s);
    checks++;
    assert (o === x.v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (rdy,shf,bf,twen,twaddr[3],ov,last,busy,perr)",
             x.tag, o, x.v);
    end
  endtask

  // Drives one cycle of inputs, queues its expectation, checks mid-cycle, then steps a clock.
  task automatic applyStimulus(int s, bit r, bit v, bit f, logic [10:0] e, string tag);
    exp_t x;
    rst_v[s] = r;
    iv_v[s]  = v;
    fl_v[s]  = f;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
    #3;
    checkOutput(s);
    @(posedge clk);
    #1;
  endtask

  // STAGE 0 (D=8) beat in RUN at counter value c with a sample present.
  function automatic logic [10:0] runBeat0(logic [3:0] c);
    bit b;
    b = c[3];
    return mk(1, 1, b, !b, b ? 3'd0 : c[2:0], 1, c == 4'd7, 1, perr0);
  endfunction

  // Feeds frame samples from index k0 to 15 into STAGE 0 starting from IDLE.
  task automatic runFrame0(int k0, string tag);
    for (int k = k0; k < 16; k++) begin
      if (k == 0)
        applyStimulus(0, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, perr0), $sformatf("%s_s%0d", tag, k + 1));
      else if (k < 8)
        applyStimulus(0, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, perr0), $sformatf("%s_s%0d", tag, k + 1));
      else
        applyStimulus(0, 0, 1, 0, runBeat0(4'(k)), $sformatf("%s_s%0d", tag, k + 1));
    end
  endtask

  task automatic runBeats0(int c0, int c1, string tag);
    for (int c = c0; c <= c1; c++)
      applyStimulus(0, 0, 1, 0, runBeat0(4'(c)), $sformatf("%s_c%0d", tag, c));
  endtask

  task automatic flushBeats0(int n, bit v, string tag);
    for (int j = 0; j < n; j++)
      applyStimulus(0, 0, v, 0, mk(0, 1, 0, 1, 3'(j), 1, j == 7, 1, perr0), $sformatf("%s_f%0d", tag, j));
  endtask

  initial begin
    int         a;
    bit         v;
    bit         b;
    bit         o;
    bit         t;
    logic [3:0] c;

    rst_v = 3'b111;
    iv_v  = 3'b000;
    fl_v  = 3'b000;
    @(posedge clk);
    #1;

    // STAGE 0: reset forces every output low even with a sample offered.
    applyStimulus(0, 1, 1, 0, 11'd0, "rst0_a");
    applyStimulus(0, 1, 1, 0, 11'd0, "rst0_b");
    applyStimulus(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "idle0");

    // Full frame, flush at cnt==0, eight drain beats, back to IDLE.
    runFrame0(0, "frameA");
    applyStimulus(0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, perr0), "flushReqA");
    flushBeats0(8, 0, "drainA");
    applyStimulus(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, perr0), "idleAfterA");

    // Flush requested in RUN at cnt==5 is ignored; the stream keeps going.
    runFrame0(0, "frameB");
    runBeats0(0, 4, "runB");
    applyStimulus(0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, perr0), "flushCnt5");
    perr0 = PE;
    runBeats0(5, 15, "runB2");

    // in_valid held through the drain: stalled for D beats, then accepted in IDLE.
    applyStimulus(0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, perr0), "flushReqB");
    flushBeats0(8, 1, "drainHold");
    applyStimulus(0, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, perr0), "idleAccept");
    runFrame0(1, "frameC");

    // Sample and flush together at cnt==0: the sample wins.
    applyStimulus(0, 0, 1, 1, runBeat0(4'd0), "flushAndSample");
    runBeats0(1, 15, "runC");

    // Reset during the fourth drain cycle discards everything.
    applyStimulus(0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, perr0), "flushReqC");
    flushBeats0(3, 0, "drainC");
    perr0 = 1'b0;
    applyStimulus(0, 1, 0, 0, 11'd0, "rstInFlush_a");
    applyStimulus(0, 1, 1, 0, 11'd0, "rstInFlush_b");
    applyStimulus(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "idleAfterRst");
    runFrame0(0, "frameD");
    rst_v[0] = 1'b1;

    // STAGE 3 (D=1): 32 continuous samples, then a one-beat drain.
    applyStimulus(2, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "idle3");
    for (int k = 0; k < 32; k++) begin
      c = 4'(k);
      b = c[0];
      if (k == 0)
        applyStimulus(2, 0, 1, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0), "d1_s1");
      else
        applyStimulus(2, 0, 1, 0, mk(1, 1, b, !b, 0, 1, c == 4'd0, 1, 0), $sformatf("d1_s%0d", k + 1));
    end
    applyStimulus(2, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0, 1, 0), "d1_flushReq");
    applyStimulus(2, 0, 0, 0, mk(0, 1, 0, 1, 0, 1, 1, 1, 0), "d1_drain");
    applyStimulus(2, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "d1_idle");
    rst_v[2] = 1'b1;

    // STAGE 1 (D=4): bubble pattern 1,0,1,1,0 freezes the count on idle beats.
    applyStimulus(1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "idle1");
    a = 0;
    for (int k = 0; k < 30; k++) begin
      v = ((k % 5) == 0) || ((k % 5) == 2) || ((k % 5) == 3);
      c = 4'(a);
      b = (a > 0) ? c[2] : 1'b0;
      o = (a >= 4) && v;
      t = o && !b;
      applyStimulus(1, 0, v, 0,
                    mk(1, v, b, t, t ? {c[1:0], 1'b0} : 3'd0, o, o && (c == 4'd3), a > 0, 0),
                    $sformatf("d4_b%0d", k));
      if (v) a++;
    end
    rst_v[1] = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r2sdf_stage_ctrl.md
# r2sdf_stage_ctrl

Sequencing controller for one radix-2 delay-feedback (SDF) stage of the 16-point FFT pipeline. It counts accepted samples and drives three things: the stage's delay-line shift enable, the butterfly/pass-through mux select, and the twiddle ROM address. It also generates output valid and frame markers, and drains the delay line at end of stream. It contains no datapath; the butterfly, delay FIFO and twiddle multiplier are external and consume its controls.

## Interface
- N, 16, FFT length (power of two, ≥2); LOG2N = log2(N) derived locally
- STAGE, 0, stage index 0..LOG2N-1; delay D = N >> (STAGE+1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  controller accepts sample this cycle
- flush  in  1  request drain of delay line (level, sampled each cycle)
- dl_shift  out  1  advance delay line and datapath this cycle
- bf_sel  out  1  1 = butterfly mode (sum out, diff into delay); 0 = fill mode (input into delay, delay out)
- tw_en  out  1  output beat carries a delayed diff needing twiddle multiply
- tw_addr  out  LOG2N-1  twiddle index, W_N^tw_addr
- out_valid  out  1  stage output beat valid
- out_last  out  1  final output beat of a frame
- busy  out  1  state ≠ IDLE
- proto_err  out  1  sticky protocol error (see Configuration)

## Operation
- State register: IDLE, FILL, RUN, FLUSH.
- Counter cnt is LOG2N bits and wraps N-1→0. It advances on every cycle where adv = (in_valid & in_ready) | (state==FLUSH).
- dl_shift = adv.
- bf_sel = cnt[log2 D] in FILL and RUN; 0 in IDLE and FLUSH.
- IDLE: in_ready=1, cnt=0. Accepted sample → FILL.
- FILL: in_ready=1, out_valid=0. Leave for RUN on the accept that makes cnt reach D; the D-th sample has been accepted at that point.
- RUN: in_ready=1; out_valid = in_valid.
  - flush is honoured only when cnt==0 and no sample is accepted in that cycle: go to FLUSH.
  - flush with cnt≠0 is ignored.
- FLUSH:
  - in_ready=0; out_valid=1 every cycle for D cycles, with cnt running 0..D-1.
  - After the cycle with cnt==D-1: go to IDLE and reset cnt to 0.
- tw_en = out_valid & ~bf_sel.
- tw_addr = (cnt mod D) << STAGE when tw_en; otherwise 0.
- out_last = out_valid & (cnt == D-1). This marks output sample index N-1, since output index = (cnt − D) mod N.
- busy = (state ≠ IDLE).
- in_valid during FLUSH is not accepted; upstream holds the sample.

## Timing
- State, cnt and proto_err are registered. All other outputs are combinational decodes of state, cnt and in_valid, valid in the same cycle.
- Latency: first out_valid coincides with accepted input sample D+1, i.e. D accepted beats after the first accept.
- Throughput: one sample per clock; bubbles (in_valid=0) freeze cnt and deassert dl_shift and out_valid.
- While rst=1: state←IDLE, cnt←0, proto_err←0. Every output is forced 0 during rst, including in_ready.
- Reset mid-frame or mid-FLUSH discards progress; the first cycle after rst deasserts is IDLE with in_ready=1.
- Simultaneous flush and accepted sample at cnt==0 in RUN: the sample wins and flush is ignored that cycle.

## Configuration
- R2SDF_CTRL_PROTO_CHK_EN defined:
  - proto_err sets and holds until rst when either of these occurs:
    - flush is high in RUN with cnt≠0;
    - flush is high in FILL.
- Not defined: proto_err is tied 0 and the check logic is absent. Functional behaviour of all other outputs is identical.

## Test plan
- N=16, STAGE=0 (D=8), 16 back-to-back samples then flush at cnt==0:
  - out_valid first high on sample 9;
  - bf_sel=1 on samples 9–16;
  - FLUSH lasts 8 cycles with tw_addr 0..7;
  - out_last on the final FLUSH cycle; then IDLE, busy=0.
- STAGE=3 (D=1), continuous 32 samples:
  - bf_sel toggles every beat;
  - tw_addr always 0;
  - out_last pulses when cnt==0, every 16 outputs after the first.
- STAGE=1 (D=4), bubble pattern valid 1,0,1,1,0…: cnt, dl_shift and out_valid freeze on bubbles. In RUN, tw_addr sequence while tw_en is high is 0,2,4,6.
- flush asserted in RUN at cnt=5 (D=8): ignored, stream continues; proto_err=1 only with R2SDF_CTRL_PROTO_CHK_EN.
- rst asserted during FLUSH cycle 3: all outputs 0 while rst=1; after release, IDLE, in_ready=1, cnt restarts at 0.
- in_valid held high through FLUSH: in_ready=0 for exactly D cycles, and the pending sample is accepted in the first IDLE cycle.
